// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the two requester ports, the single-port RAM port
// and the conflict counter of ram_arbiter.
//   fetch port : if_req, if_adr -> if_gnt, if_rdata, if_rvalid
//   data port  : d_req, d_we, d_adr, d_wdata -> d_gnt, d_rdata, d_rvalid
//   RAM port   : mem_en, mem_we, mem_adr, mem_wdata <- mem_rdata
//   status     : conflict_cnt
// slave  = arbiter side, master = requesters plus RAM (the environment).
interface ram_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADR_W  = 8
) ();
    logic              if_req;
    logic [ADR_W-1:0]  if_adr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;

    logic              d_req;
    logic              d_we;
    logic [ADR_W-1:0]  d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [7:0]        conflict_cnt;

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        output if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
        output mem_en, mem_we, mem_adr, mem_wdata, conflict_cnt
    );

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        input  if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
        input  mem_en, mem_we, mem_adr, mem_wdata, conflict_cnt
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between an instruction-fetch port
// and a data port. Data wins by default; a fetch that has waited STARVE_LIMIT
// consecutive cycles is granted regardless. Grants and the RAM command are
// combinational in the request cycle; read responses (rvalid) follow one
// cycle later from a registered ownership stage, so one access per cycle is
// sustained.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ram_arbiter_if.slave (requesters, RAM, conflict_cnt)
module ram_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADR_W        = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned CNT_W    = 8;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [CNT_W-1:0]    conflict_q, conflict_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;

    logic                starved_c;
    logic                if_gnt_c;
    logic                d_gnt_c;

    // Arbitration; grants are forced low while reset is held.
    always_comb begin
        starved_c = bus.if_req && (starve_q == STARVE_MAX);
        if_gnt_c  = 1'b0;
        d_gnt_c   = 1'b0;
        if (!reset) begin
            if (bus.if_req && (starved_c || !bus.d_req)) begin
                if_gnt_c = 1'b1;
            end else if (bus.d_req) begin
                d_gnt_c = 1'b1;
            end
        end
    end

    // RAM command from the winner; everything zero when idle.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_adr   = '0;
        bus.mem_wdata = '0;
        if (if_gnt_c) begin
            bus.mem_en  = 1'b1;
            bus.mem_adr = bus.if_adr;
        end else if (d_gnt_c) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_adr   = bus.d_adr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Next-state: starve counter, conflict counter, response ownership.
    always_comb begin
        starve_d    = starve_q;
        conflict_d  = conflict_q;
        if_rvalid_d = if_gnt_c;
        d_rvalid_d  = d_gnt_c && !bus.d_we;

        if (!bus.if_req || if_gnt_c) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        if (bus.if_req && bus.d_req && (conflict_q != CNT_MAX)) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // State registers; reset also discards any response in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q    <= '0;
            conflict_q  <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            conflict_q  <= conflict_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    assign bus.if_gnt       = if_gnt_c;
    assign bus.d_gnt        = d_gnt_c;
    assign bus.if_rvalid    = if_rvalid_q;
    assign bus.d_rvalid     = d_rvalid_q;
    // Both read buses mirror the RAM; consumers qualify with their rvalid.
    assign bus.if_rdata     = bus.mem_rdata;
    assign bus.d_rdata      = bus.mem_rdata;
    assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random stimulus for ram_arbiter. A checker
// process predicts grants, RAM commands and conflict_cnt each cycle from the
// arbitration rules and queues expected read responses; a monitor process
// pops and compares them when the DUT's response cycle arrives.
module tb_ram_arbiter;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned ADR_W        = 8;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned DEPTH        = 1 << ADR_W;

    typedef struct {
        bit                port;   // 0 = fetch, 1 = data
        logic [DATA_W-1:0] data;
        int                due;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W)) bus ();

    ram_arbiter #(
        .DATA_W      (DATA_W),
        .ADR_W       (ADR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Environment RAM and the bench's independent view of its contents.
    logic [DATA_W-1:0] ram    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_adr] <= bus.mem_wdata;
            else            bus.mem_rdata    <= ram[bus.mem_adr];
        end
    end

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    resp_t exp_q[$];

    // Reference state: consecutive denied fetch cycles, expected conflict count.
    int    fetch_wait   = 0;
    int    exp_conflict = 0;
    bit    last_if_won  = 1'b0;
    bit    last_d_won   = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Checker: predict this cycle's grant and RAM command.
    always @(negedge clk) begin
        bit                exp_i, exp_d, exp_en, exp_we;
        logic [ADR_W-1:0]  exp_adr;
        logic [DATA_W-1:0] exp_wd;
        if (reset) begin
            check("rst_if_gnt",   32'(bus.if_gnt), 32'd0);
            check("rst_d_gnt",    32'(bus.d_gnt), 32'd0);
            check("rst_mem_en",   32'(bus.mem_en), 32'd0);
            check("rst_mem_we",   32'(bus.mem_we), 32'd0);
            check("rst_mem_adr",  32'(bus.mem_adr), 32'd0);
            check("rst_mem_wd",   32'(bus.mem_wdata), 32'd0);
            check("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
            fetch_wait   = 0;
            exp_conflict = 0;
            last_if_won  = 1'b0;
            last_d_won   = 1'b0;
        end else begin
            exp_i   = bus.if_req && (!bus.d_req || fetch_wait >= int'(STARVE_LIMIT));
            exp_d   = bus.d_req && !exp_i;
            exp_en  = exp_i || exp_d;
            exp_we  = exp_d && bus.d_we;
            exp_adr = exp_i ? bus.if_adr : (exp_d ? bus.d_adr : '0);
            exp_wd  = exp_d ? bus.d_wdata : '0;

            check("if_gnt",    32'(bus.if_gnt), 32'(exp_i));
            check("d_gnt",     32'(bus.d_gnt), 32'(exp_d));
            check("mem_en",    32'(bus.mem_en), 32'(exp_en));
            check("mem_we",    32'(bus.mem_we), 32'(exp_we));
            check("mem_adr",   32'(bus.mem_adr), 32'(exp_adr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wd));
            check("conflict",  32'(bus.conflict_cnt), 32'(exp_conflict));

            if (exp_i) exp_q.push_back('{1'b0, shadow[bus.if_adr], cyc + 1});
            if (exp_d && !bus.d_we) exp_q.push_back('{1'b1, shadow[bus.d_adr], cyc + 1});
            if (exp_d && bus.d_we) shadow[bus.d_adr] = bus.d_wdata;

            if (bus.if_req && !exp_i)
                fetch_wait = (fetch_wait < int'(STARVE_LIMIT)) ? fetch_wait + 1 : fetch_wait;
            else
                fetch_wait = 0;
            if (bus.if_req && bus.d_req && exp_conflict < 255) exp_conflict++;

            last_if_won = exp_i;
            last_d_won  = exp_d;
        end
    end

    // Monitor: compare read responses against the queue.
    always @(negedge clk) begin
        resp_t e;
        if (reset) begin
            exp_q.delete();
            check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
            check("rst_d_rvalid",  32'(bus.d_rvalid), 32'd0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("if_rvalid", 32'(bus.if_rvalid), 32'(!e.port));
            check("d_rvalid",  32'(bus.d_rvalid), 32'(e.port));
            if (e.port) check("d_rdata",  32'(bus.d_rdata), 32'(e.data));
            else        check("if_rdata", 32'(bus.if_rdata), 32'(e.data));
        end else begin
            check("idle_if_rvalid", 32'(bus.if_rvalid), 32'd0);
            check("idle_d_rvalid",  32'(bus.d_rvalid), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.if_req  = 1'b0;
        bus.if_adr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_adr   = '0;
        bus.d_wdata = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = DATA_W'(i * 257) ^ 16'h5A5A;
            ram[i]    = v;
            shadow[i] = v;
        end
        ram[8'h10]    = 16'hBEEF;
        shadow[8'h10] = 16'hBEEF;
        bus.mem_rdata = '0;
        idle_reqs();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Lone fetch read of 0xBEEF.
        bus.if_req = 1'b1;
        bus.if_adr = 8'h10;
        step();
        idle_reqs();
        step();

        // Lone data write, then read it back.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_adr   = 8'h20;
        bus.d_wdata = 16'h1234;
        step();
        bus.d_we    = 1'b0;
        bus.d_wdata = '0;
        step();
        idle_reqs();
        step();

        // Alternating fetch/data reads.
        for (int i = 0; i < 6; i++) begin
            idle_reqs();
            if (i % 2 == 0) begin
                bus.if_req = 1'b1;
                bus.if_adr = 8'h01;
            end else begin
                bus.d_req = 1'b1;
                bus.d_adr = 8'h02;
            end
            step();
        end
        idle_reqs();
        step();

        // Both held: data wins until fetch has waited STARVE_LIMIT cycles.
        bus.if_req = 1'b1;
        bus.if_adr = 8'h40;
        bus.d_req  = 1'b1;
        bus.d_adr  = 8'h30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_if_gnt", 32'(bus.if_gnt), 32'((i == 4) || (i == 9)));
        end
        @(posedge clk);
        #1;
        check("conflict_after_10", 32'(bus.conflict_cnt), 32'd10);
        idle_reqs();
        step();

        // Data read granted, reset pulsed in the response cycle.
        bus.d_req = 1'b1;
        bus.d_adr = 8'h05;
        step();
        idle_reqs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("conflict_after_reset", 32'(bus.conflict_cnt), 32'd0);

        // Random traffic; a request is held until the reference grants it.
        for (int i = 0; i < 400; i++) begin
            if (last_if_won) bus.if_req = 1'b0;
            if (last_d_won)  bus.d_req  = 1'b0;
            if (!bus.if_req && $urandom_range(0, 3) != 0) begin
                bus.if_req = 1'b1;
                bus.if_adr = ADR_W'($urandom_range(0, 15));
            end
            if (!bus.d_req && $urandom_range(0, 3) != 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = $urandom_range(0, 1) == 1;
                bus.d_adr   = ADR_W'($urandom_range(0, 15));
                bus.d_wdata = DATA_W'($urandom);
            end
            step();
        end
        idle_reqs();
        step();

        // Saturation of conflict_cnt.
        bus.if_req = 1'b1;
        bus.if_adr = 8'h03;
        bus.d_req  = 1'b1;
        bus.d_adr  = 8'h04;
        repeat (300) step();
        check("conflict_sat", 32'(bus.conflict_cnt), 32'd255);
        repeat (5) step();
        check("conflict_hold", 32'(bus.conflict_cnt), 32'd255);
        idle_reqs();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, as the RAM word width.
REQ-002 The block SHALL expose parameter ADR_W, default 8, as the RAM address width.
REQ-003 The block SHALL expose parameter STARVE_LIMIT, default 4, as the consecutive fetch-wait cycles that force a fetch grant (legal range 1..15).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_req  input  1  instruction-fetch read request.
REQ-007 if_adr  input  ADR_W  fetch address (program counter).
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rdata  output  DATA_W  fetch read data.
REQ-010 if_rvalid  output  1  if_rdata valid this cycle.
REQ-011 d_req  input  1  data-port request.
REQ-012 d_we  input  1  data request is a write (1) or read (0).
REQ-013 d_adr  input  ADR_W  data address.
REQ-014 d_wdata  input  DATA_W  data write value.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rdata  output  DATA_W  data read data.
REQ-017 d_rvalid  output  1  d_rdata valid this cycle.
REQ-018 mem_en  output  1  single-port RAM access enable.
REQ-019 mem_we  output  1  RAM write enable.
REQ-020 mem_adr  output  ADR_W  RAM address.
REQ-021 mem_wdata  output  DATA_W  RAM write data.
REQ-022 mem_rdata  input  DATA_W  RAM read data, valid one cycle after a read with mem_en=1.
REQ-023 conflict_cnt  output  8  saturating count of cycles with if_req and d_req both high.

Function
REQ-024 At most one of if_gnt and d_gnt SHALL be high in any cycle; grants are combinational, in the same cycle as the winning request.
REQ-025 Default priority SHALL be data over fetch: d_req=1 grants data unless the starvation override (REQ-027) is active.
REQ-026 A 4-bit starve counter SHALL increment each cycle with if_req=1 and if_gnt=0, saturate at STARVE_LIMIT, and clear on any cycle with if_gnt=1 or if_req=0.
REQ-027 When starve counter == STARVE_LIMIT and if_req=1, fetch SHALL be granted regardless of d_req.
REQ-028 In a grant cycle mem_en SHALL be 1 and mem_adr, mem_we, mem_wdata SHALL come from the winner; a fetch grant drives mem_we=0 and mem_wdata=0.
REQ-029 With no grant: mem_en=0, mem_we=0, mem_adr=0, mem_wdata=0.
REQ-030 A granted read SHALL assert exactly one of if_rvalid/d_rvalid, chosen by winner, for one cycle in the cycle after the grant (latency 1); a granted write SHALL assert no rvalid.
REQ-031 if_rdata and d_rdata SHALL both equal mem_rdata; consumers qualify them with their rvalid.
REQ-032 Back-to-back grants SHALL be allowed every cycle; read-response ownership SHALL be a registered one-cycle pipeline stage, so sustained throughput is one access per cycle.
REQ-033 Requesters SHALL hold req, adr, we and wdata stable until granted; the arbiter has no request buffering.
REQ-034 conflict_cnt SHALL increment by 1 on each cycle with if_req=1 and d_req=1, and hold at 255.

Reset
REQ-035 While reset=1: if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid =0; mem_adr, mem_wdata =0; starve counter and conflict_cnt =0; pending-response state cleared.
REQ-036 A read granted in the cycle reset asserts, or whose response falls during reset, SHALL never produce an rvalid.
REQ-037 After reset deasserts, arbitration SHALL resume on the next rising edge with no residual priority state.

Verification
REQ-038 if_req=1 if_adr=0x10 alone, mem_rdata=0xBEEF next cycle -> if_gnt=1, mem_adr=0x10, mem_we=0; next cycle if_rvalid=1, if_rdata=0xBEEF, d_rvalid=0.
REQ-039 d_req=1 d_we=1 d_adr=0x20 d_wdata=0x1234 alone -> d_gnt=1, mem_en=1, mem_we=1, mem_adr=0x20, mem_wdata=0x1234; no rvalid next cycle.
REQ-040 if_req and d_req (read) held high continuously, STARVE_LIMIT=4 -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt cycles 5-8, if_gnt cycle 9; conflict_cnt=10 after 10 cycles.
REQ-041 Alternating fetch read at 0x01 and data read at 0x02 on successive cycles -> rvalids alternate if/d each cycle, each one cycle after its grant, never both high.
REQ-042 Data read granted at cycle N, reset pulsed high during cycle N+1 -> d_rvalid=0 throughout; all outputs zero while reset=1; conflict_cnt=0 after release.
REQ-043 300 cycles with both requests high -> conflict_cnt saturates and holds 255.
